// File: rtl/riscv_pipeline_cpu.sv
// Five-stage RV32 subset core (IF/ID/EX/MEM/WB) with operand forwarding,
// load-use stalling and branch resolution in ID.
module riscv_pipeline_cpu (
  input logic clk_i,
  input logic rst_i,
  input logic start_i
);
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_XOR = 3'd3,
                         ALU_SLL = 3'd4, ALU_SRA = 3'd5, ALU_MUL = 3'd6;

  function automatic logic signed [31:0] alu_f(input logic [2:0] op,
                                               input logic signed [31:0] a,
                                               input logic signed [31:0] b);
    case (op)
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_XOR: return a ^ b;
      ALU_SLL: return a << b[4:0];
      ALU_SRA: return a >>> b[4:0];
      ALU_MUL: return a * b;
      default: return a + b;
    endcase
  endfunction

  logic [31:0] pc, instr_if, br_target;
  logic        stall;
  wire         Flush;

  // IF
  rv_pc PC (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall),
    .flush_i(Flush), .target_i(br_target), .pc_o(pc)
  );

  rv_imem Instruction_Memory (.addr_i(pc[9:2]), .instr_o(instr_if));

  logic [31:0] pc_p0, instr_p0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_p0    <= '0;
      instr_p0 <= '0;
    end else if (Flush) begin
      pc_p0    <= '0;
      instr_p0 <= '0;
    end else if (!stall) begin
      pc_p0    <= pc;
      instr_p0 <= instr_if;
    end
  end

  // ID
  logic [4:0]  rs1_id, rs2_id, rd_id;
  logic [31:0] imm_id, rd1_id, rd2_id, wb_data;
  logic        regwrite_id, memtoreg_id, memread_id, memwrite_id, alusrc_id, branch_id;
  logic [2:0]  aluop_id;
  logic        regwrite_p3;
  logic [4:0]  rd_p3;
  logic        memread_p1;
  logic [4:0]  rd_p1;

  assign rs1_id = instr_p0[19:15];
  assign rs2_id = instr_p0[24:20];
  assign rd_id  = instr_p0[11:7];

  always_comb begin
    case (instr_p0[6:0])
      7'b0100011: imm_id = {{20{instr_p0[31]}}, instr_p0[31:25], instr_p0[11:7]};
      7'b1100011: imm_id = {{19{instr_p0[31]}}, instr_p0[31], instr_p0[7],
                            instr_p0[30:25], instr_p0[11:8], 1'b0};
      default:    imm_id = {{20{instr_p0[31]}}, instr_p0[31:20]};
    endcase
  end

  rv_control Control (
    .opcode_i(instr_p0[6:0]), .funct3_i(instr_p0[14:12]), .funct7_i(instr_p0[31:25]),
    .RegWrite_o(regwrite_id), .MemtoReg_o(memtoreg_id), .MemRead_o(memread_id),
    .MemWrite_o(memwrite_id), .ALUSrc_o(alusrc_id), .Branch_o(branch_id), .ALUOp_o(aluop_id)
  );

  rv_regfile Registers (
    .clk_i(clk_i), .rs1_i(rs1_id), .rs2_i(rs2_id), .rd_i(rd_p3), .wdata_i(wb_data),
    .we_i(regwrite_p3), .rdata1_o(rd1_id), .rdata2_o(rd2_id)
  );

  rv_hazard Hazard_Detection (
    .memread_i(memread_p1), .rd_i(rd_p1), .rs1_i(rs1_id), .rs2_i(rs2_id), .Stall_o(stall)
  );

  // Branch compare sees only register-file outputs; no EX/MEM forwarding here.
  assign Flush     = branch_id & (rd1_id == rd2_id);
  assign br_target = pc_p0 + imm_id;

  logic        regwrite_p1, memtoreg_p1, memwrite_p1, alusrc_p1;
  logic [2:0]  aluop_p1;
  logic [31:0] rd1_p1, rd2_p1, imm_p1;
  logic [4:0]  rs1_p1, rs2_p1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      regwrite_p1 <= 1'b0;
      memtoreg_p1 <= 1'b0;
      memread_p1  <= 1'b0;
      memwrite_p1 <= 1'b0;
      alusrc_p1   <= 1'b0;
      aluop_p1    <= '0;
      rd1_p1      <= '0;
      rd2_p1      <= '0;
      imm_p1      <= '0;
      rs1_p1      <= '0;
      rs2_p1      <= '0;
      rd_p1       <= '0;
    end else begin
      regwrite_p1 <= regwrite_id & ~stall;
      memtoreg_p1 <= memtoreg_id & ~stall;
      memread_p1  <= memread_id & ~stall;
      memwrite_p1 <= memwrite_id & ~stall;
      alusrc_p1   <= alusrc_id & ~stall;
      aluop_p1    <= stall ? ALU_ADD : aluop_id;
      rd1_p1      <= rd1_id;
      rd2_p1      <= rd2_id;
      imm_p1      <= imm_id;
      rs1_p1      <= rs1_id;
      rs2_p1      <= rs2_id;
      rd_p1       <= rd_id;
    end
  end

  // EX
  logic        regwrite_p2, memtoreg_p2, memwrite_p2;
  logic [31:0] alu_p2, sdata_p2;
  logic [4:0]  rd_p2;
  logic [31:0] fwd_a, fwd_b, alu_res;

  always_comb begin
    fwd_a = rd1_p1;
    if (regwrite_p2 && rd_p2 != 5'd0 && rd_p2 == rs1_p1)      fwd_a = alu_p2;
    else if (regwrite_p3 && rd_p3 != 5'd0 && rd_p3 == rs1_p1) fwd_a = wb_data;
    fwd_b = rd2_p1;
    if (regwrite_p2 && rd_p2 != 5'd0 && rd_p2 == rs2_p1)      fwd_b = alu_p2;
    else if (regwrite_p3 && rd_p3 != 5'd0 && rd_p3 == rs2_p1) fwd_b = wb_data;
  end

  assign alu_res = alu_f(aluop_p1, fwd_a, alusrc_p1 ? imm_p1 : fwd_b);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      regwrite_p2 <= 1'b0;
      memtoreg_p2 <= 1'b0;
      memwrite_p2 <= 1'b0;
      alu_p2      <= '0;
      sdata_p2    <= '0;
      rd_p2       <= '0;
    end else begin
      regwrite_p2 <= regwrite_p1;
      memtoreg_p2 <= memtoreg_p1;
      memwrite_p2 <= memwrite_p1;
      alu_p2      <= alu_res;
      sdata_p2    <= fwd_b;
      rd_p2       <= rd_p1;
    end
  end

  // MEM
  logic [31:0] mem_rdata;
  logic        memtoreg_p3;
  logic [31:0] alu_p3, mem_p3;

  rv_dmem Data_Memory (
    .clk_i(clk_i), .we_i(memwrite_p2), .addr_i(alu_p2[6:2]),
    .wdata_i(sdata_p2), .rdata_o(mem_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      regwrite_p3 <= 1'b0;
      memtoreg_p3 <= 1'b0;
      alu_p3      <= '0;
      mem_p3      <= '0;
      rd_p3       <= '0;
    end else begin
      regwrite_p3 <= regwrite_p2;
      memtoreg_p3 <= memtoreg_p2;
      alu_p3      <= alu_p2;
      mem_p3      <= mem_rdata;
      rd_p3       <= rd_p2;
    end
  end

  // WB
  assign wb_data = memtoreg_p3 ? mem_p3 : alu_p3;
endmodule

// Program counter: redirect on flush, hold on stall, advance only while running.
module rv_pc (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o
);
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)           pc_o <= '0;
    else if (start_i) begin
      if (flush_i)        pc_o <= target_i;
      else if (!stall_i)  pc_o <= pc_o + 32'd4;
    end
  end
endmodule

// Combinational-read instruction ROM, loaded externally.
module rv_imem (
  input  logic [7:0]  addr_i,
  output logic [31:0] instr_o
);
  logic [31:0] memory [0:255];
  assign instr_o = memory[addr_i];
endmodule

// Word data memory: synchronous write, combinational read.
module rv_dmem (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);
  logic [31:0] memory [0:31];
  always_ff @(posedge clk_i) begin
    if (we_i) memory[addr_i] <= wdata_i;
  end
  assign rdata_o = memory[addr_i];
endmodule

// 32x32 register file with write-through bypass; x0 is hardwired to zero.
module rv_regfile (
  input  logic        clk_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);
  logic [31:0] register [0:31];

  always_ff @(posedge clk_i) begin
    if (we_i && rd_i != 5'd0) register[rd_i] <= wdata_i;
  end

  always_comb begin
    rdata1_o = register[rs1_i];
    if (rs1_i == 5'd0)                rdata1_o = '0;
    else if (we_i && rd_i == rs1_i)   rdata1_o = wdata_i;
    rdata2_o = register[rs2_i];
    if (rs2_i == 5'd0)                rdata2_o = '0;
    else if (we_i && rd_i == rs2_i)   rdata2_o = wdata_i;
  end
endmodule

// Load-use hazard: the load in EX targets a source of the instruction in ID.
module rv_hazard (
  input  logic       memread_i,
  input  logic [4:0] rd_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  output logic       Stall_o
);
  assign Stall_o = memread_i && (rd_i != 5'd0) && ((rd_i == rs1_i) || (rd_i == rs2_i));
endmodule

// Main decoder; unrecognised encodings leave every control at 0 (NOP).
module rv_control (
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic       RegWrite_o,
  output logic       MemtoReg_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       ALUSrc_o,
  output logic       Branch_o,
  output logic [2:0] ALUOp_o
);
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_XOR = 3'd3,
                         ALU_SLL = 3'd4, ALU_SRA = 3'd5, ALU_MUL = 3'd6;

  always_comb begin
    RegWrite_o = 1'b0;
    MemtoReg_o = 1'b0;
    MemRead_o  = 1'b0;
    MemWrite_o = 1'b0;
    ALUSrc_o   = 1'b0;
    Branch_o   = 1'b0;
    ALUOp_o    = ALU_ADD;
    case (opcode_i)
      7'b0110011: begin
        RegWrite_o = 1'b1;
        case ({funct7_i, funct3_i})
          {7'b0000000, 3'b111}: ALUOp_o = ALU_AND;
          {7'b0000000, 3'b100}: ALUOp_o = ALU_XOR;
          {7'b0000000, 3'b001}: ALUOp_o = ALU_SLL;
          {7'b0000000, 3'b000}: ALUOp_o = ALU_ADD;
          {7'b0100000, 3'b000}: ALUOp_o = ALU_SUB;
          {7'b0000001, 3'b000}: ALUOp_o = ALU_MUL;
          default:              RegWrite_o = 1'b0;
        endcase
      end
      7'b0010011: begin
        if (funct3_i == 3'b000) begin
          RegWrite_o = 1'b1;
          ALUSrc_o   = 1'b1;
        end else if (funct3_i == 3'b101 && funct7_i == 7'b0100000) begin
          RegWrite_o = 1'b1;
          ALUSrc_o   = 1'b1;
          ALUOp_o    = ALU_SRA;
        end
      end
      7'b0000011: begin
        if (funct3_i == 3'b010) begin
          RegWrite_o = 1'b1;
          MemtoReg_o = 1'b1;
          MemRead_o  = 1'b1;
          ALUSrc_o   = 1'b1;
        end
      end
      7'b0100011: begin
        if (funct3_i == 3'b010) begin
          MemWrite_o = 1'b1;
          ALUSrc_o   = 1'b1;
        end
      end
      7'b1100011: Branch_o = (funct3_i == 3'b000);
      default: ;
    endcase
  end
endmodule

// File: tb/tb_riscv_pipeline_cpu.sv
// Directed program bench for riscv_pipeline_cpu; memories and registers are preloaded hierarchically.
module tb_riscv_pipeline_cpu;
  logic clk_i   = 1'b0;
  logic rst_i   = 1'b0;
  logic start_i = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  int stall_cnt, flush_cnt, hold_cnt;
  logic [31:0] prev_pc;

  localparam logic [6:0] OP_IMM = 7'b0010011, OP_LOAD = 7'b0000011;

  riscv_pipeline_cpu dut (.clk_i(clk_i), .rst_i(rst_i), .start_i(start_i));

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic hold_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'h0;
    dut.Registers.register[0] = 32'h0;
    @(negedge clk_i);
  endtask

  task automatic run(input int n);
    stall_cnt = 0;
    flush_cnt = 0;
    hold_cnt  = 0;
    prev_pc   = dut.PC.pc_o;
    repeat (n) begin
      @(negedge clk_i);
      stall_cnt += int'(dut.Hazard_Detection.Stall_o);
      flush_cnt += int'(dut.Flush);
      if (dut.PC.pc_o == prev_pc) hold_cnt++;
      prev_pc = dut.PC.pc_o;
    end
  endtask

  initial begin
    // reset, idle and sequential fetch over NOPs
    hold_reset();
    dut.Registers.register[5] = 32'd15;
    check("rst_pc", dut.PC.pc_o, 32'd0);
    check("rst_stall", {31'd0, dut.Hazard_Detection.Stall_o}, 32'd0);
    check("rst_flush", {31'd0, dut.Flush}, 32'd0);
    rst_i = 1'b1;
    run(3);
    check("idle_pc", dut.PC.pc_o, 32'd0);
    start_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      run(1);
      check($sformatf("fetch_pc%0d", k), dut.PC.pc_o, 32'(4 * k));
    end
    run(4);
    check("nop_x5", dut.Registers.register[5], 32'd15);
    check("nop_stall", stall_cnt, 0);
    check("nop_flush", flush_cnt, 0);

    // ALU forwarding from EX/MEM and MEM/WB
    hold_reset();
    dut.Registers.register[1] = 32'hdead;
    dut.Registers.register[2] = 32'hdead;
    dut.Registers.register[3] = 32'hdead;
    dut.Instruction_Memory.memory[0] = enc_i(12'd10, 5'd0, 3'b000, 5'd1, OP_IMM);
    dut.Instruction_Memory.memory[1] = enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd2);
    dut.Instruction_Memory.memory[2] = enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd3);
    rst_i = 1'b1;
    run(10);
    check("fwd_x1", dut.Registers.register[1], 32'd10);
    check("fwd_x2", dut.Registers.register[2], 32'd20);
    check("fwd_x3", dut.Registers.register[3], 32'd10);
    check("fwd_stall", stall_cnt, 0);

    // load-use stall
    hold_reset();
    dut.Data_Memory.memory[1] = 32'd6;
    dut.Registers.register[4] = 32'hdead;
    dut.Registers.register[5] = 32'hdead;
    dut.Instruction_Memory.memory[0] = enc_i(12'd4, 5'd0, 3'b010, 5'd4, OP_LOAD);
    dut.Instruction_Memory.memory[1] = enc_r(7'h00, 5'd4, 5'd4, 3'b000, 5'd5);
    rst_i = 1'b1;
    run(10);
    check("lu_x4", dut.Registers.register[4], 32'd6);
    check("lu_x5", dut.Registers.register[5], 32'd12);
    check("lu_stall", stall_cnt, 1);
    check("lu_hold", hold_cnt, 1);

    // store and mixed ALU ops
    hold_reset();
    dut.Data_Memory.memory[2] = 32'h0;
    dut.Registers.register[1]  = 32'd1;
    dut.Registers.register[24] = 32'hFFFFFFE8;
    dut.Registers.register[25] = 32'hFFFFFFE7;
    dut.Registers.register[28] = 32'd56;
    dut.Instruction_Memory.memory[0] = enc_s(12'd8, 5'd28, 5'd0);
    dut.Instruction_Memory.memory[1] = enc_r(7'h01, 5'd25, 5'd24, 3'b000, 5'd6);
    dut.Instruction_Memory.memory[2] = enc_i({7'b0100000, 5'd2}, 5'd24, 3'b101, 5'd7, OP_IMM);
    dut.Instruction_Memory.memory[3] = enc_r(7'h00, 5'd24, 5'd28, 3'b100, 5'd8);
    dut.Instruction_Memory.memory[4] = enc_r(7'h00, 5'd1, 5'd28, 3'b001, 5'd9);
    rst_i = 1'b1;
    run(12);
    check("sw_mem2", dut.Data_Memory.memory[2], 32'd56);
    check("mul_x6", dut.Registers.register[6], 32'd600);
    check("srai_x7", dut.Registers.register[7], 32'hFFFFFFFA);
    check("xor_x8", dut.Registers.register[8], 32'hFFFFFFD0);
    check("sll_x9", dut.Registers.register[9], 32'd112);

    // taken branch flushes the wrong-path instruction
    hold_reset();
    dut.Registers.register[10] = 32'd0;
    dut.Registers.register[11] = 32'hbad;
    dut.Instruction_Memory.memory[0] = enc_b(13'd8, 5'd0, 5'd0);
    dut.Instruction_Memory.memory[1] = enc_i(12'd1, 5'd0, 3'b000, 5'd10, OP_IMM);
    dut.Instruction_Memory.memory[2] = enc_i(12'd2, 5'd0, 3'b000, 5'd11, OP_IMM);
    rst_i = 1'b1;
    run(10);
    check("bt_flush", flush_cnt, 1);
    check("bt_x10", dut.Registers.register[10], 32'd0);
    check("bt_x11", dut.Registers.register[11], 32'd2);

    // untaken branch falls through
    hold_reset();
    dut.Registers.register[1]  = 32'd5;
    dut.Registers.register[10] = 32'd0;
    dut.Registers.register[11] = 32'hbad;
    dut.Instruction_Memory.memory[0] = enc_b(13'd8, 5'd0, 5'd1);
    dut.Instruction_Memory.memory[1] = enc_i(12'd1, 5'd0, 3'b000, 5'd10, OP_IMM);
    dut.Instruction_Memory.memory[2] = enc_i(12'd2, 5'd0, 3'b000, 5'd11, OP_IMM);
    rst_i = 1'b1;
    run(10);
    check("bn_flush", flush_cnt, 0);
    check("bn_x10", dut.Registers.register[10], 32'd1);
    check("bn_x11", dut.Registers.register[11], 32'd2);

    // x0 protection and EX/MEM forwarding priority
    hold_reset();
    dut.Registers.register[12] = 32'h77;
    dut.Registers.register[13] = 32'h77;
    dut.Registers.register[14] = 32'h77;
    dut.Instruction_Memory.memory[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd0, OP_IMM);
    dut.Instruction_Memory.memory[1] = enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd12);
    dut.Instruction_Memory.memory[2] = enc_i(12'd1, 5'd0, 3'b000, 5'd13, OP_IMM);
    dut.Instruction_Memory.memory[3] = enc_i(12'd2, 5'd0, 3'b000, 5'd13, OP_IMM);
    dut.Instruction_Memory.memory[4] = enc_r(7'h00, 5'd13, 5'd13, 3'b000, 5'd14);
    rst_i = 1'b1;
    run(12);
    check("x0_keep", dut.Registers.register[0], 32'd0);
    check("x0_x12", dut.Registers.register[12], 32'd0);
    check("pri_x13", dut.Registers.register[13], 32'd2);
    check("pri_x14", dut.Registers.register[14], 32'd4);

    // asynchronous reset mid-run, then restart from 0
    #2 rst_i = 1'b0;
    #1 check("async_pc", dut.PC.pc_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    run(1);
    check("restart_pc", dut.PC.pc_o, 32'd4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
